// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master side feeds bytes and observes writes; the loader is the slave.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed little-endian byte-stream loader that fills instruction memory
// and holds the core in reset until done. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FINAL_STATE = CHK;
`else
  localparam state_t FINAL_STATE = DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                state, next_state;
  logic [7:0]            n_lo;
  logic [15:0]           n_words;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [23:0]           word_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic        xfer;
  logic        restart;
  logic [15:0] n_hdr;
  logic        last_word;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign restart   = start && (state == IDLE || state == DONE || state == ERR);
  assign n_hdr     = {bus.in_data, n_lo};
  assign last_word = (16'(word_idx) == n_words - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = HDR0;
      HDR0:            if (xfer) next_state = HDR1;
      HDR1: if (xfer) begin
        if (n_hdr == 16'd0)                next_state = FINAL_STATE;
        else if ({1'b0, n_hdr} > MAX_WORDS) next_state = ERR;
        else                                next_state = DATA;
      end
      DATA: if (xfer && lane == 2'd3 && last_word) next_state = FINAL_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (xfer) next_state = (bus.in_data == csum) ? DONE : ERR;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CHK);
    core_hold    = (state != DONE);
    done         = (state == DONE);
    error        = (state == ERR);
  end

  // The word index stops at N-1 so a full 2^ADDR_WIDTH image never wraps the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_lo           <= '0;
      n_words        <= '0;
      word_idx       <= '0;
      lane           <= '0;
      word_buf       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      if (restart) begin
        word_idx <= '0;
        lane     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (xfer && state == HDR0) n_lo    <= bus.in_data;
      if (xfer && state == HDR1) n_words <= n_hdr;
      if (xfer && state == DATA) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ bus.in_data;
`endif
        case (lane)
          2'd0: word_buf[7:0]   <= bus.in_data;
          2'd1: word_buf[15:8]  <= bus.in_data;
          2'd2: word_buf[23:16] <= bus.in_data;
          default: begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= word_idx;
            bus.imem_wdata <= {bus.in_data, word_buf};
            if (!last_word) word_idx <= word_idx + 1'b1;
          end
        endcase
        lane <= lane + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN
// to decide whether a trailing checksum byte is sent.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic core_hold, done, error;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cycle[$];

  imem_loader_if #(.ADDR_WIDTH(8)) bus ();

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus.slave),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Each posedge closes a cycle; log any write strobe that was high during it.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      wr_cycle.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL byte_accept_timeout observed=in_ready %b expected=1", bus.in_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic idleCycles(input int n);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clearLog();
    wr_addr.delete();
    wr_data.delete();
    wr_cycle.delete();
  endtask

  // Sends header+payload (and checksum when enabled, XORed with csum_flip); gap inserts idle cycles between bytes.
  task automatic sendImage(input logic [7:0] bytes[$], input int gap, input logic [7:0] csum_flip);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < bytes.size(); i++) begin
      if (i >= 2) x = x ^ bytes[i];
      applyStimulus(bytes[i]);
      if (gap > 0 && i != bytes.size() - 1) idleCycles(gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (gap > 0) idleCycles(gap);
    applyStimulus(x ^ csum_flip);
`else
    if (csum_flip != 8'h00) x = 8'h00;
`endif
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] img2[$];
    logic [7:0] img_dead[$];
    logic [7:0] img_zero[$];
    img2     = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    img_dead = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    img_zero = '{8'h00, 8'h00};

    rst = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready",  32'(bus.in_ready), 32'd0);
    checkOutput("rst_we",        32'(bus.imem_we), 32'd0);
    checkOutput("rst_addr",      32'(bus.imem_addr), 32'd0);
    checkOutput("rst_wdata",     bus.imem_wdata, 32'd0);
    checkOutput("rst_core_hold", 32'(core_hold), 32'd1);
    checkOutput("rst_done",      32'(done), 32'd0);
    checkOutput("rst_error",     32'(error), 32'd0);
    rst = 1'b1;
    idleCycles(2);
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Full-throughput load of two words.
    pulseStart();
    checkOutput("start_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("load_core_hold", 32'(core_hold), 32'd1);
    sendImage(img2, 0, 8'h00);
`ifndef IMEM_LOADER_CHECKSUM_EN
    checkOutput("last_we_with_done", 32'(bus.imem_we), 32'd1);
`endif
    checkOutput("t1_done",      32'(done), 32'd1);
    checkOutput("t1_core_hold", 32'(core_hold), 32'd0);
    checkOutput("t1_in_ready",  32'(bus.in_ready), 32'd0);
    idleCycles(1);
    checkOutput("t1_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      checkOutput("t1_addr0",  32'(wr_addr[0]), 32'd0);
      checkOutput("t1_data0",  wr_data[0], 32'h00500093);
      checkOutput("t1_addr1",  32'(wr_addr[1]), 32'd1);
      checkOutput("t1_data1",  wr_data[1], 32'h00A00113);
      checkOutput("t1_cadence", 32'(wr_cycle[1] - wr_cycle[0]), 32'd4);
    end

    // Restart from DONE, then same image with valid toggling and a stray start mid-DATA.
    clearLog();
    pulseStart();
    checkOutput("restart_core_hold", 32'(core_hold), 32'd1);
    checkOutput("restart_done",      32'(done), 32'd0);
    checkOutput("restart_in_ready",  32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(img2[i]);
      idleCycles(1);
    end
    pulseStart();
    checkOutput("start_in_data_ignored", 32'(bus.in_ready), 32'd1);
    img2 = img2[3:$];
    img2.push_front(8'h00);
    img2.push_front(8'h00);
    // Header placeholders above are skipped by sending from index 2 onward.
    for (int i = 2; i < img2.size(); i++) begin
      applyStimulus(img2[i]);
      if (i != img2.size() - 1) idleCycles(1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    idleCycles(1);
    applyStimulus(8'h71);
`endif
    bus.in_valid = 1'b0;
    checkOutput("t2_done", 32'(done), 32'd1);
    idleCycles(1);
    checkOutput("t2_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      checkOutput("t2_addr0", 32'(wr_addr[0]), 32'd0);
      checkOutput("t2_data0", wr_data[0], 32'h00500093);
      checkOutput("t2_addr1", 32'(wr_addr[1]), 32'd1);
      checkOutput("t2_data1", wr_data[1], 32'h00A00113);
    end

    // Oversized header 0x0101 > 256 words.
    clearLog();
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    checkOutput("big_error",     32'(error), 32'd1);
    checkOutput("big_core_hold", 32'(core_hold), 32'd1);
    checkOutput("big_in_ready",  32'(bus.in_ready), 32'd0);
    checkOutput("big_done",      32'(done), 32'd0);
    bus.in_data = 8'h55;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("big_no_we", 32'(wr_addr.size()), 32'd0);

    // Zero-length image.
    pulseStart();
    checkOutput("zero_error_cleared", 32'(error), 32'd0);
    sendImage(img_zero, 0, 8'h00);
    checkOutput("zero_done", 32'(done), 32'd1);
    idleCycles(1);
    checkOutput("zero_no_we", 32'(wr_addr.size()), 32'd0);

    // Asynchronous reset after five payload bytes, then a one-word reload.
    pulseStart();
    for (int i = 0; i < 7; i++) applyStimulus(img2[i] == 8'h00 && i < 2 ? (i == 0 ? 8'h02 : 8'h00) : img2[i]);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_in_ready",  32'(bus.in_ready), 32'd0);
    checkOutput("abort_core_hold", 32'(core_hold), 32'd1);
    checkOutput("abort_wdata",     bus.imem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clearLog();
    pulseStart();
    sendImage(img_dead, 0, 8'h00);
    checkOutput("dead_done", 32'(done), 32'd1);
    idleCycles(1);
    checkOutput("dead_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      checkOutput("dead_addr", 32'(wr_addr[0]), 32'd0);
      checkOutput("dead_data", wr_data[0], 32'hDEADBEEF);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match (0x44) and mismatch (0x45) on word 0x11223344.
    clearLog();
    pulseStart();
    sendImage('{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}, 0, 8'h00);
    checkOutput("csum_ok_done", 32'(done), 32'd1);
    clearLog();
    pulseStart();
    sendImage('{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}, 0, 8'h01);
    checkOutput("csum_bad_error",     32'(error), 32'd1);
    checkOutput("csum_bad_core_hold", 32'(core_hold), 32'd1);
    idleCycles(1);
    checkOutput("csum_bad_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) checkOutput("csum_bad_data", wr_data[0], 32'h11223344);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
